// File: rtl/mem_responder.sv
// Byte-wide memory responder with programmable wait states and a side loader port.
// Optional address range checking is enabled with the MEM_RESPONDER_BOUNDS_EN macro.
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic              op_wr_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic              req_c;
  logic              collide_c;
  logic              adr_ok_c;
  logic              ld_ok_c;
  logic [IDX_W-1:0]  idx_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_wadr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign req_c     = memread ^ memwrite;
  assign collide_c = memread & memwrite;
  assign idx_c     = IDX_W'(adr_q);

`ifdef MEM_RESPONDER_BOUNDS_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  assign adr_ok_c = ({1'b0, adr_q} < DEPTH_L);
  assign ld_ok_c  = ({1'b0, ld_adr} < DEPTH_L);
`else
  assign adr_ok_c = 1'b1;
  assign ld_ok_c  = 1'b1;
`endif

  // Single storage write port: loader in IDLE, core write commit in RESP.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_wadr_c  = IDX_W'(ld_adr);
    mem_wdata_c = ld_data;
    if (reset && state == S_IDLE && ld_en) begin
      mem_we_c = ld_ok_c;
    end else if (reset && state == S_RESP && op_wr_q) begin
      mem_we_c    = adr_ok_c;
      mem_wadr_c  = idx_c;
      mem_wdata_c = wdata_q;
    end
  end

  // Storage is deliberately not reset so preloaded contents survive a core reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_wadr_c] <= mem_wdata_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      memdata <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      op_wr_q <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Loader has priority; a held core request is taken on a later idle cycle.
          if (ld_en) begin
            if (!ld_ok_c) begin
              err <= 1'b1;
            end
          end else if (collide_c) begin
            err <= 1'b1;
          end else if (req_c) begin
            op_wr_q <= memwrite;
            adr_q   <= adr;
            wdata_q <= writedata;
            cnt     <= CNT_W'(WAIT_CYCLES);
            busy    <= 1'b1;
            state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!op_wr_q) begin
            memdata <= adr_ok_c ? mem[idx_c] : '0;
          end
          if (!adr_ok_c) begin
            err <= 1'b1;
          end
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a WAIT_CYCLES=1/DEPTH=256 instance and a
// WAIT_CYCLES=0/DEPTH=128 instance checked against an array-based reference model.
module tb_mem_responder;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int W0 = 1;
  localparam int W1 = 0;
`ifdef MEM_RESPONDER_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          memread   [2];
  logic          memwrite  [2];
  logic          ld_en     [2];
  logic [AW-1:0] adr       [2];
  logic [AW-1:0] ld_adr    [2];
  logic [DW-1:0] writedata [2];
  logic [DW-1:0] ld_data   [2];
  logic [DW-1:0] memdata   [2];
  logic          ready     [2];
  logic          busy      [2];
  logic          err       [2];

  int     checks = 0;
  int     fails  = 0;
  longint cyc    = 0;

  logic [7:0] model0 [256];
  logic [7:0] model1 [128];

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .WAIT_CYCLES(W0)) dut (
    .clk(clk), .reset(reset), .memread(memread[0]), .memwrite(memwrite[0]),
    .adr(adr[0]), .writedata(writedata[0]), .memdata(memdata[0]), .ready(ready[0]),
    .busy(busy[0]), .err(err[0]), .ld_en(ld_en[0]), .ld_adr(ld_adr[0]), .ld_data(ld_data[0])
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(128), .WAIT_CYCLES(W1)) dut_b (
    .clk(clk), .reset(reset), .memread(memread[1]), .memwrite(memwrite[1]),
    .adr(adr[1]), .writedata(writedata[1]), .memdata(memdata[1]), .ready(ready[1]),
    .busy(busy[1]), .err(err[1]), .ld_en(ld_en[1]), .ld_adr(ld_adr[1]), .ld_data(ld_data[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected read value of the DEPTH=128 instance.
  function automatic logic [7:0] exp1(input logic [7:0] a);
    if (BOUNDS && a >= 8'h80) return 8'h00;
    return model1[a[6:0]];
  endfunction

  // Issues one request at the current negedge and waits (bounded) for ready.
  task automatic access(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input bit ld_mid, output int lat, output int busy_n,
                        output logic [7:0] rdata, output bit err_rdy, output bit err_any,
                        output longint rcyc);
    int n;
    n = 0; lat = -1; busy_n = 0; rdata = 'x; err_rdy = 1'b0; err_any = 1'b0; rcyc = 0;
    memread[i] = !wr; memwrite[i] = wr; adr[i] = a; writedata[i] = d;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy[i]) busy_n++;
      if (err[i]) err_any = 1'b1;
      if (n == 1) begin
        adr[i] = 8'($urandom);
        writedata[i] = 8'($urandom);
        if (ld_mid) begin
          ld_en[i] = 1'b1; ld_adr[i] = a; ld_data[i] = d;
        end
      end
      if (n == 2) ld_en[i] = 1'b0;
      if (ready[i]) begin
        lat = n - 1; rdata = memdata[i]; err_rdy = err[i]; rcyc = cyc;
        break;
      end
    end
    memread[i] = 1'b0; memwrite[i] = 1'b0; ld_en[i] = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      memread[i] = 0; memwrite[i] = 0; ld_en[i] = 0;
      adr[i] = '0; ld_adr[i] = '0; writedata[i] = '0; ld_data[i] = '0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({memdata[i], ready[i], busy[i], err[i]} !== 11'h0) begin
        fails++;
        $display("FAIL reset_outputs inst%0d: got memdata=%h ready=%b busy=%b err=%b, expected all zero",
                 i, memdata[i], ready[i], busy[i], err[i]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] d0, d1;
      d0 = 8'($urandom); d1 = 8'($urandom);
      ld_en[0] = 1'b1; ld_adr[0] = 8'(a); ld_data[0] = d0; model0[a] = d0;
      ld_en[1] = (a < 128); ld_adr[1] = 8'(a); ld_data[1] = d1;
      if (a < 128) model1[a] = d1;
      @(negedge clk);
    end
    ld_en[0] = 1'b0; ld_en[1] = 1'b0;
  endtask

  task automatic test_loader_fetch;
    int lat, bn; logic [7:0] rd; bit er, ea; longint rc;
    ld_en[0] = 1'b1; ld_adr[0] = 8'h00; ld_data[0] = 8'h8C;
    @(negedge clk);
    ld_adr[0] = 8'h01; ld_data[0] = 8'h12;
    @(negedge clk);
    ld_en[0] = 1'b0;
    model0[0] = 8'h8C; model0[1] = 8'h12;
    access(0, 1'b0, 8'h00, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (lat !== 2 || rd !== 8'h8C) begin
      fails++; $display("FAIL loader_fetch0: got lat=%0d data=%h, expected lat=2 data=8c", lat, rd);
    end
    access(0, 1'b0, 8'h01, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (lat !== 2 || rd !== 8'h12) begin
      fails++; $display("FAIL loader_fetch1: got lat=%0d data=%h, expected lat=2 data=12", lat, rd);
    end
  endtask

  task automatic test_write_read;
    int lat, bn; logic [7:0] rd; bit er, ea; longint rc;
    access(0, 1'b1, 8'h40, 8'hA5, 1'b0, lat, bn, rd, er, ea, rc);
    model0[8'h40] = 8'hA5;
    checks++;
    if (lat !== 2 || bn !== 2 || ea !== 1'b0) begin
      fails++; $display("FAIL write_timing: got lat=%0d busy=%0d err=%b, expected 2/2/0", lat, bn, ea);
    end
    checks++;
    if (memdata[0] !== 8'h12) begin
      fails++; $display("FAIL memdata_hold: got %h expected 12", memdata[0]);
    end
    // Loader pulse during WAIT must be ignored.
    access(0, 1'b0, 8'h40, 8'h5A, 1'b1, lat, bn, rd, er, ea, rc);
    checks++;
    if (lat !== 2 || bn !== 2 || rd !== 8'hA5) begin
      fails++; $display("FAIL read_after_write: got lat=%0d busy=%0d data=%h, expected 2/2/a5", lat, bn, rd);
    end
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b0) begin
      fails++; $display("FAIL ready_one_cycle: got ready=%b expected 0", ready[0]);
    end
    access(0, 1'b0, 8'h40, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (rd !== 8'hA5) begin
      fails++; $display("FAIL loader_ignored_busy: got %h expected a5", rd);
    end
  endtask

  task automatic test_collision;
    int lat, bn; logic [7:0] rd, old, d; bit er, ea; longint rc;
    old = model0[5];
    memread[0] = 1'b1; memwrite[0] = 1'b1; adr[0] = 8'h05; writedata[0] = ~old;
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b1 || ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++; $display("FAIL collision_err: got err=%b ready=%b busy=%b, expected 1/0/0", err[0], ready[0], busy[0]);
    end
    memread[0] = 1'b0; memwrite[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b0) begin
      fails++; $display("FAIL collision_pulse: got err=%b expected 0", err[0]);
    end
    access(0, 1'b0, 8'h05, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (rd !== old || lat !== 2) begin
      fails++; $display("FAIL collision_nowrite: got data=%h lat=%0d, expected %h/2", rd, lat, old);
    end
    d = 8'($urandom) ^ model0[8'h22] ^ 8'h01;
    ld_en[0] = 1'b1; ld_adr[0] = 8'h22; ld_data[0] = d;
    memread[0] = 1'b1; adr[0] = 8'h22;
    @(negedge clk);
    ld_en[0] = 1'b0; model0[8'h22] = d;
    checks++;
    if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      fails++; $display("FAIL loader_priority: got busy=%b ready=%b, expected 0/0", busy[0], ready[0]);
    end
    access(0, 1'b0, 8'h22, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (rd !== d || lat !== 2) begin
      fails++; $display("FAIL loader_then_read: got data=%h lat=%0d, expected %h/2", rd, lat, d);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bn; logic [7:0] rd, old; bit er, ea; longint rc;
    access(0, 1'b0, 8'h40, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    old = model0[8'h10];
    memwrite[0] = 1'b1; adr[0] = 8'h10; writedata[0] = ~old;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      fails++; $display("FAIL reset_mid_busy: got busy=%b expected 1", busy[0]);
    end
    reset = 1'b0; memwrite[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({memdata[0], ready[0], busy[0], err[0]} !== 11'h0) begin
      fails++; $display("FAIL reset_mid_outputs: got memdata=%h ready=%b busy=%b err=%b, expected all zero",
                        memdata[0], ready[0], busy[0], err[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    access(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (rd !== old) begin
      fails++; $display("FAIL reset_abort_write: got %h expected %h", rd, old);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn; logic [7:0] rd; bit er, ea; longint rc0, rc1;
    access(1, 1'b0, 8'h00, 8'h00, 1'b0, lat, bn, rd, er, ea, rc0);
    checks++;
    if (lat !== 1 || bn !== 1 || rd !== model1[0]) begin
      fails++; $display("FAIL b2b_first: got lat=%0d busy=%0d data=%h, expected 1/1/%h", lat, bn, rd, model1[0]);
    end
    access(1, 1'b0, 8'h01, 8'h00, 1'b0, lat, bn, rd, er, ea, rc1);
    checks++;
    if (lat !== 1 || rd !== model1[1] || (rc1 - rc0) !== 64'sd2) begin
      fails++; $display("FAIL b2b_second: got lat=%0d data=%h gap=%0d, expected 1/%h/2", lat, rd, rc1 - rc0, model1[1]);
    end
  endtask

  task automatic test_bounds;
    int lat, bn; logic [7:0] rd, d; bit er, ea; longint rc;
    access(1, 1'b0, 8'h80, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (rd !== exp1(8'h80) || er !== BOUNDS || lat !== 1) begin
      fails++; $display("FAIL bounds_read: got data=%h err=%b lat=%0d, expected %h/%b/1", rd, er, lat, exp1(8'h80), BOUNDS);
    end
    d = model1[5] ^ 8'h3C;
    access(1, 1'b1, 8'h85, d, 1'b0, lat, bn, rd, er, ea, rc);
    if (!BOUNDS) model1[5] = d;
    checks++;
    if (er !== BOUNDS || lat !== 1) begin
      fails++; $display("FAIL bounds_write: got err=%b lat=%0d, expected %b/1", er, lat, BOUNDS);
    end
    access(1, 1'b0, 8'h05, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (rd !== model1[5]) begin
      fails++; $display("FAIL bounds_write_effect: got %h expected %h", rd, model1[5]);
    end
    d = model1[8'h10] ^ 8'hC3;
    ld_en[1] = 1'b1; ld_adr[1] = 8'h90; ld_data[1] = d;
    @(negedge clk);
    ld_en[1] = 1'b0;
    if (!BOUNDS) model1[8'h10] = d;
    checks++;
    if (err[1] !== BOUNDS) begin
      fails++; $display("FAIL bounds_loader_err: got %b expected %b", err[1], BOUNDS);
    end
    access(1, 1'b0, 8'h10, 8'h00, 1'b0, lat, bn, rd, er, ea, rc);
    checks++;
    if (rd !== model1[8'h10]) begin
      fails++; $display("FAIL bounds_loader_effect: got %h expected %h", rd, model1[8'h10]);
    end
  endtask

  task automatic test_random;
    int lat, bn, i, wl; logic [7:0] rd, a, d, ex; bit wr, er, ea, oob; longint rc;
    for (int k = 0; k < 80; k++) begin
      i = int'($urandom_range(1, 0)); wr = 1'($urandom); a = 8'($urandom); d = 8'($urandom);
      wl = (i == 0) ? W0 : W1;
      oob = (i == 1) && BOUNDS && (a >= 8'h80);
      ex = (i == 0) ? model0[a] : exp1(a);
      access(i, wr, a, d, 1'b0, lat, bn, rd, er, ea, rc);
      checks++;
      if (lat !== wl + 1 || bn !== wl + 1 || er !== oob || (!wr && rd !== ex)) begin
        fails++;
        $display("FAIL random_%0d inst%0d %s adr=%h: got lat=%0d busy=%0d err=%b data=%h, expected %0d/%0d/%b/%h",
                 k, i, wr ? "wr" : "rd", a, lat, bn, er, rd, wl + 1, wl + 1, oob, ex);
      end
      if (wr && i == 0) model0[a] = d;
      if (wr && i == 1 && !oob) model1[a[6:0]] = d;
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_loader_fetch();
    test_write_read();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_bounds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Byte-wide memory responder that sits at the far end of the multicycle processor's memory interface.
- Accepts the processor's memread/memwrite/adr/writedata requests and returns memdata plus a ready pulse after a programmable number of wait states.
- Provides a side loader port so a bench or boot block can preload program bytes before the core runs.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data width in bits.
- DEPTH, 256, number of storage words; must be a power of 2, no greater than 2**ADDR_W.
- WAIT_CYCLES, 1, wait states between request capture and response (0..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; state is cleared when reset = 0.
- memread  input  1  read request from the core.
- memwrite  input  1  write request from the core.
- adr  input  ADDR_W  request address.
- writedata  input  DATA_W  write data.
- memdata  output  DATA_W  read data; holds its value between reads.
- ready  output  1  one-cycle pulse when the request completes.
- busy  output  1  high while in WAIT or RESP.
- err  output  1  one-cycle error pulse.
- ld_en  input  1  loader write strobe.
- ld_adr  input  ADDR_W  loader address.
- ld_data  input  DATA_W  loader data.

Behaviour:
- Reset (async, reset = 0):
  - state = IDLE; memdata = 0, ready = 0, busy = 0, err = 0; wait counter = 0.
  - Storage array is not cleared.
- State machine IDLE / WAIT / RESP:
  - IDLE, ld_en = 1: mem[ld_adr] <= ld_data that edge. Loader wins over a same-cycle core request. The request is not captured and must be held by the requester; it is taken the next IDLE cycle with ld_en = 0.
  - IDLE, exactly one of memread/memwrite = 1, ld_en = 0:
    - Capture op, adr and writedata into registers; load counter = WAIT_CYCLES.
    - Go to WAIT, or straight to RESP if WAIT_CYCLES = 0.
  - IDLE, memread = 1 and memwrite = 1: nothing is captured; err pulses on the next cycle; stay IDLE.
  - WAIT: decrement the counter; go to RESP when it reaches 0. Inputs are ignored, so captured values are used even if adr changes.
  - RESP:
    - Read: memdata <= mem[adr_q]. Write: mem[adr_q] <= wdata_q.
    - ready = 1 for exactly this cycle.
    - Next state is IDLE. A new request can be captured the cycle after RESP.
- Latency: capture edge to ready high is WAIT_CYCLES + 1 cycles. memdata is valid in the same cycle ready is high.
- Read-after-write to the same address returns the new data, because the write commits in RESP before any later capture.
- ld_en outside IDLE is ignored.
- Address wrap: the address is taken modulo DEPTH (low log2(DEPTH) bits).
- Reset mid-operation: the request is aborted; a pending write that has not reached RESP is not committed.

Optional Feature:
- Macro: MEM_RESPONDER_BOUNDS_EN.
- Defined:
  - A captured address >= DEPTH still completes normally with a ready pulse.
  - err pulses in the RESP cycle.
  - A read returns 0; a write is dropped.
  - A loader address >= DEPTH is ignored and pulses err.
- Undefined: no range check; addresses wrap modulo DEPTH; err is driven only by simultaneous memread and memwrite.

Test Plan:
- Reset: hold reset = 0 for 2 cycles mid-WAIT -> memdata = 0x00, ready = 0, busy = 0, err = 0; the pending write to 0x10 does not appear on a later read of 0x10.
- Loader then fetch: ld 0x00 = 0x8C, 0x01 = 0x12 with WAIT_CYCLES = 1; memread adr = 0x00 -> ready 2 cycles after capture, memdata = 0x8C; next read of 0x01 -> memdata = 0x12.
- Write then read: memwrite adr = 0x40 data = 0xA5, then memread 0x40 -> memdata = 0xA5 with ready; busy high exactly 2 cycles per access.
- Collision: memread = memwrite = 1 at adr = 0x05 -> err pulse, no ready, mem[0x05] unchanged. ld_en together with memread -> loader commits first, read served the next IDLE cycle.
- WAIT_CYCLES = 0 build: back-to-back reads of 0x00 and 0x01 -> ready every other cycle, latency 1.
- DEPTH = 128 with MEM_RESPONDER_BOUNDS_EN: read adr = 0x80 -> memdata = 0x00 with err and ready. Without the macro: read 0x80 returns mem[0x00].
